// File: rtl/psram_spi_responder_pkg.sv
// rtl/psram_spi_responder_pkg.sv - shared opcodes, state encoding and address width for the PSRAM responder
package psram_pkg;

  localparam logic [7:0] OP_READ   = 8'h03;
  localparam logic [7:0] OP_FREAD  = 8'h0B;
  localparam logic [7:0] OP_WRITE  = 8'h02;
  localparam int         ADDR_BITS = 24;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DUMMY,
    ST_RDATA,
    ST_WDATA,
    ST_IGNORE
  } state_t;

  // Opcodes that carry an address phase and touch the backing store
  function automatic logic is_mem_op(input logic [7:0] op);
    return (op == OP_READ) || (op == OP_FREAD) || (op == OP_WRITE);
  endfunction

endpackage

// File: rtl/psram_spi_responder_if.sv
// rtl/psram_spi_responder_if.sv - SPI pin bundle between initiator and PSRAM responder
interface psram_spi_responder_if;
  logic psram_ce;
  logic psram_sclk;
  logic psram_mosi;
  logic psram_miso;
  logic psram_miso_oe;

  modport master (
    output psram_ce, psram_sclk, psram_mosi,
    input  psram_miso, psram_miso_oe
  );

  modport slave (
    input  psram_ce, psram_sclk, psram_mosi,
    output psram_miso, psram_miso_oe
  );
endinterface

// File: rtl/psram_spi_responder_edge_sync.sv
// rtl/psram_spi_responder_edge_sync.sv - 2-FF synchronizers and edge strobes for ce/sclk/mosi
module spi_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic ce_i,
  input  logic sclk_i,
  input  logic mosi_i,
  output logic mosi_o,
  output logic sclk_rise_o,
  output logic sclk_fall_o,
  output logic ce_rise_o,
  output logic ce_fall_o
);

  logic ce_meta_q, ce_sync_q, ce_dly_q;
  logic sclk_meta_q, sclk_sync_q, sclk_dly_q;
  logic mosi_meta_q, mosi_sync_q;

  // Two-stage synchronizers plus one delay stage for edge detection; reset to bus idle levels
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ce_meta_q   <= 1'b1;
      ce_sync_q   <= 1'b1;
      ce_dly_q    <= 1'b1;
      sclk_meta_q <= 1'b0;
      sclk_sync_q <= 1'b0;
      sclk_dly_q  <= 1'b0;
      mosi_meta_q <= 1'b0;
      mosi_sync_q <= 1'b0;
    end else begin
      ce_meta_q   <= ce_i;
      ce_sync_q   <= ce_meta_q;
      ce_dly_q    <= ce_sync_q;
      sclk_meta_q <= sclk_i;
      sclk_sync_q <= sclk_meta_q;
      sclk_dly_q  <= sclk_sync_q;
      mosi_meta_q <= mosi_i;
      mosi_sync_q <= mosi_meta_q;
    end
  end

  assign mosi_o      = mosi_sync_q;
  assign sclk_rise_o =  sclk_sync_q & ~sclk_dly_q;
  assign sclk_fall_o = ~sclk_sync_q &  sclk_dly_q;
  assign ce_rise_o   =  ce_sync_q   & ~ce_dly_q;
  assign ce_fall_o   = ~ce_sync_q   &  ce_dly_q;

endmodule

// File: rtl/psram_spi_responder.sv
// rtl/psram_spi_responder.sv - SPI PSRAM responder with an internal byte-wide backing store
module psram_spi_responder
  import psram_pkg::*;
#(
  parameter int MEM_AW        = 10,
  parameter int CLK_RATIO_MIN = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  psram_spi_responder_if.slave    spi,
  output logic                    busy,
  output logic [7:0]              last_cmd
);

  // Below a 4:1 ratio the synchronizer latency eats the whole sclk half period;
  // the ratio is documentation only, so nothing is generated here.
  if (CLK_RATIO_MIN < 4) begin : g_ratio_below_sync_latency
  end

  logic mosi_s, sclk_rise, sclk_fall, ce_rise, ce_fall;

  spi_edge_sync u_sync (
    .clk         (clk),
    .rst         (rst),
    .ce_i        (spi.psram_ce),
    .sclk_i      (spi.psram_sclk),
    .mosi_i      (spi.psram_mosi),
    .mosi_o      (mosi_s),
    .sclk_rise_o (sclk_rise),
    .sclk_fall_o (sclk_fall),
    .ce_rise_o   (ce_rise),
    .ce_fall_o   (ce_fall)
  );

  state_t                 state_q, state_d;
  logic [4:0]             bit_cnt_q, bit_cnt_d;
  logic [2:0]             tx_idx_q, tx_idx_d;
  logic [7:0]             shift_q, shift_d;
  logic [ADDR_BITS-1:0]   addr_q, addr_d;
  logic [7:0]             last_cmd_q, last_cmd_d;
  logic                   miso_q, miso_d;
  logic                   oe_q, oe_d;

  logic [7:0]             mem [0:(1<<MEM_AW)-1];
  logic [7:0]             mem_rdata_q;
  logic                   mem_we, mem_re;
  logic [MEM_AW-1:0]      mem_idx;
  logic [7:0]             mem_wdata;

  logic [7:0]             shift_nx;
  logic [ADDR_BITS-1:0]   addr_nx, addr_inc;

  assign shift_nx = {shift_q[6:0], mosi_s};
  assign addr_nx  = {addr_q[ADDR_BITS-2:0], mosi_s};
  assign addr_inc = addr_q + 1'b1;

  // Protocol state and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      tx_idx_q   <= '0;
      shift_q    <= '0;
      addr_q     <= '0;
      last_cmd_q <= '0;
      miso_q     <= 1'b0;
      oe_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      tx_idx_q   <= tx_idx_d;
      shift_q    <= shift_d;
      addr_q     <= addr_d;
      last_cmd_q <= last_cmd_d;
      miso_q     <= miso_d;
      oe_q       <= oe_d;
    end
  end

  // Next state: ce edges override any coincident sclk edge, so a write can never land on ce rise
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    tx_idx_d   = tx_idx_q;
    shift_d    = shift_q;
    addr_d     = addr_q;
    last_cmd_d = last_cmd_q;
    miso_d     = miso_q;
    oe_d       = oe_q;
    mem_we     = 1'b0;
    mem_re     = 1'b0;
    mem_idx    = addr_q[MEM_AW-1:0];
    mem_wdata  = shift_nx;

    if (ce_rise || ce_fall) begin
      state_d   = ce_rise ? ST_IDLE : ST_CMD;
      bit_cnt_d = '0;
      tx_idx_d  = '0;
      miso_d    = 1'b0;
      oe_d      = 1'b0;
    end else begin
      unique case (state_q)
        ST_CMD: if (sclk_rise) begin
          shift_d   = shift_nx;
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 5'd7) begin
            last_cmd_d = shift_nx;
            bit_cnt_d  = '0;
            state_d    = is_mem_op(shift_nx) ? ST_ADDR : ST_IGNORE;
          end
        end
        ST_ADDR: if (sclk_rise) begin
          addr_d    = addr_nx;
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 5'(ADDR_BITS - 1)) begin
            bit_cnt_d = '0;
            if (last_cmd_q == OP_FREAD) begin
              state_d = ST_DUMMY;
            end else if (last_cmd_q == OP_READ) begin
              state_d = ST_RDATA;
              mem_re  = 1'b1;
              mem_idx = addr_nx[MEM_AW-1:0];
            end else begin
              state_d = ST_WDATA;
            end
          end
        end
        ST_DUMMY: if (sclk_rise) begin
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 5'd7) begin
            bit_cnt_d = '0;
            state_d   = ST_RDATA;
            mem_re    = 1'b1;
          end
        end
        ST_RDATA: if (sclk_fall) begin
          oe_d     = 1'b1;
          miso_d   = mem_rdata_q[~tx_idx_q];
          tx_idx_d = tx_idx_q + 1'b1;
          if (tx_idx_q == 3'd7) begin
            addr_d  = addr_inc;
            mem_re  = 1'b1;
            mem_idx = addr_inc[MEM_AW-1:0];
          end
        end
        ST_WDATA: if (sclk_rise) begin
          shift_d   = shift_nx;
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 5'd7) begin
            mem_we    = 1'b1;
            addr_d    = addr_inc;
            bit_cnt_d = '0;
          end
        end
        ST_IDLE, ST_IGNORE: ;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Single-port synchronous byte RAM; contents survive reset
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_idx] <= mem_wdata;
    end else if (mem_re) begin
      mem_rdata_q <= mem[mem_idx];
    end
  end

  assign spi.psram_miso    = miso_q;
  assign spi.psram_miso_oe = oe_q;
  assign busy              = (state_q != ST_IDLE);
  assign last_cmd          = last_cmd_q;

endmodule

// File: tb/tb_psram_spi_responder.sv
// tb/tb_psram_spi_responder.sv - scoreboard bench for psram_spi_responder
module tb_psram_spi_responder;

  logic       clk;
  logic       rst;
  logic       busy;
  logic [7:0] last_cmd;

  psram_spi_responder_if spi();

  psram_spi_responder #(.MEM_AW(10), .CLK_RATIO_MIN(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .spi      (spi),
    .busy     (busy),
    .last_cmd (last_cmd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  bit         oe_bad;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: collects miso bits at each sclk fall while the driver is enabled
  initial begin : monitor
    int         nbits;
    logic [7:0] sh;
    nbits = 0;
    sh    = '0;
    forever begin
      @(negedge spi.psram_sclk or posedge spi.psram_ce or posedge rst);
      if (spi.psram_ce || rst) begin
        nbits = 0;
      end else if (spi.psram_miso_oe) begin
        sh = {sh[6:0], spi.psram_miso};
        nbits++;
        if (nbits == 8) begin
          nbits = 0;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rd_byte: got %0h expected none", sh);
          end else begin
            check("rd_byte", {24'h0, sh}, {24'h0, exp_q.pop_front()});
          end
        end
      end
    end
  end

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Mode-0 bits, MSB first; ctrl marks phases where the responder must not drive miso
  task automatic spi_bits(input logic [7:0] v, input int n, input bit ctrl);
    for (int i = 7; i > 7 - n; i--) begin
      spi.psram_mosi = v[i];
      clks(2);
      spi.psram_sclk = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      if (ctrl && spi.psram_miso_oe) oe_bad = 1'b1;
      #1;
      spi.psram_sclk = 1'b0;
    end
  endtask

  task automatic begin_txn(input logic [7:0] op, input logic [23:0] addr, input bit with_addr);
    oe_bad = 1'b0;
    spi.psram_ce = 1'b0;
    clks(2);
    spi_bits(op, 8, 1);
    if (with_addr) begin
      spi_bits(addr[23:16], 8, 1);
      spi_bits(addr[15:8], 8, 1);
      spi_bits(addr[7:0], 8, 1);
    end
  endtask

  task automatic end_txn(input string name);
    clks(2);
    spi.psram_ce = 1'b1;
    clks(8);
    check(name, {31'h0, oe_bad}, 32'h0);
  endtask

  task automatic do_write(input logic [23:0] addr, input logic [31:0] data, input int n);
    begin_txn(8'h02, addr, 1);
    for (int i = 0; i < n; i++) spi_bits(data[31-8*i -: 8], 8, 1);
    end_txn("oe_during_write");
  endtask

  task automatic do_read(input logic [7:0] op, input logic [23:0] addr, input int n);
    begin_txn(op, addr, 1);
    if (op == 8'h0B) spi_bits(8'h00, 8, 1);
    for (int i = 0; i < n; i++) spi_bits(8'hFF, 8, 0);
    end_txn("oe_before_data");
  endtask

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stimulus
    int n;
    rst = 1'b1;
    spi.psram_ce   = 1'b1;
    spi.psram_sclk = 1'b0;
    spi.psram_mosi = 1'b0;
    oe_bad = 1'b0;
    clks(3);
    check("reset_oe",       {31'h0, spi.psram_miso_oe}, 32'h0);
    check("reset_miso",     {31'h0, spi.psram_miso},    32'h0);
    check("reset_busy",     {31'h0, busy},              32'h0);
    check("reset_last_cmd", {24'h0, last_cmd},          32'h0);
    rst = 1'b0;
    clks(4);

    do_write(24'h000010, 32'hA55AC33C, 4);
    check("last_cmd_write", {24'h0, last_cmd}, 32'h02);

    exp_q.push_back(8'hA5); exp_q.push_back(8'h5A);
    exp_q.push_back(8'hC3); exp_q.push_back(8'h3C);
    do_read(8'h03, 24'h000010, 4);

    exp_q.push_back(8'h5A); exp_q.push_back(8'hC3); exp_q.push_back(8'h3C);
    do_read(8'h0B, 24'h000011, 3);
    check("last_cmd_fread", {24'h0, last_cmd}, 32'h0B);

    do_write(24'h0003FF, 32'h11220000, 2);
    exp_q.push_back(8'h22);
    do_read(8'h03, 24'h000000, 1);
    exp_q.push_back(8'h11);
    do_read(8'h03, 24'h0003FF, 1);

    begin_txn(8'h9F, 24'h0, 0);
    spi_bits(8'h00, 8, 1); spi_bits(8'h00, 8, 1);
    spi_bits(8'h10, 8, 1); spi_bits(8'hFF, 8, 1);
    end_txn("oe_ignore");
    check("last_cmd_ignore", {24'h0, last_cmd}, 32'h9F);
    exp_q.push_back(8'hA5); exp_q.push_back(8'h5A);
    exp_q.push_back(8'hC3); exp_q.push_back(8'h3C);
    do_read(8'h03, 24'h000010, 4);

    begin_txn(8'h02, 24'h000010, 1);
    spi_bits(8'h00, 5, 1);
    clks(2);
    spi.psram_ce = 1'b1;
    n = 10;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (!busy) begin
        n = i + 1;
        break;
      end
    end
    check("busy_drop_le3", {31'h0, (n <= 3)}, 32'h1);
    clks(8);
    exp_q.push_back(8'hA5);
    do_read(8'h03, 24'h000010, 1);

    exp_q.push_back(8'h5A);
    begin_txn(8'h03, 24'h000011, 1);
    spi_bits(8'hFF, 8, 0);
    spi_bits(8'hFF, 3, 0);
    clks(1);
    rst = 1'b1;
    spi.psram_ce = 1'b1;
    #1;
    check("rst_oe",       {31'h0, spi.psram_miso_oe}, 32'h0);
    check("rst_last_cmd", {24'h0, last_cmd},          32'h0);
    check("rst_busy",     {31'h0, busy},              32'h0);
    clks(3);
    rst = 1'b0;
    clks(8);
    exp_q.push_back(8'hC3); exp_q.push_back(8'h3C);
    do_read(8'h03, 24'h000012, 2);

    clks(10);
    check("scoreboard_drained", exp_q.size(), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/psram_spi_responder.md
PSRAM_SPI_RESPONDER -- requirements
Module: psram_spi_responder

Interface
REQ-001 SHALL have parameter MEM_AW, default 10, meaning log2 of the backing-store depth in bytes.
REQ-002 SHALL have parameter CLK_RATIO_MIN, default 4, meaning the documented minimum clk/sclk frequency ratio; it is not checked in hardware.
REQ-003 SHALL have port clk, input, 1, the single system clock.
REQ-004 SHALL have port rst, input, 1, reset: asynchronous, active-high.
REQ-005 SHALL have port psram_ce, input, 1, chip enable, active-low.
REQ-006 SHALL have port psram_sclk, input, 1, SPI clock, mode 0.
REQ-007 SHALL have port psram_mosi, input, 1, serial data from the initiator.
REQ-008 SHALL have port psram_miso, output, 1, serial data to the initiator.
REQ-009 SHALL have port psram_miso_oe, output, 1, high while the miso driver is enabled.
REQ-010 SHALL have port busy, output, 1, high while a transaction is in progress (ce low, state not IDLE).
REQ-011 SHALL have port last_cmd, output, 8, opcode of the most recent transaction.

Function
REQ-012 SHALL pass psram_ce, psram_sclk and psram_mosi through 2-FF synchronizers, then detect sclk rise/fall edges from the synchronized value and its one-cycle delay.
REQ-013 SHALL sample mosi only on a detected sclk rise, MSB first.
REQ-014 SHALL update miso only on a detected sclk fall.
REQ-015 SHALL implement states IDLE, CMD, ADDR, DUMMY, RDATA, WDATA, IGNORE.
REQ-016 SHALL move IDLE->CMD on synchronized ce falling, clearing the bit counter.
REQ-017 In CMD, after 8 bits, SHALL latch last_cmd and go to ADDR for opcodes 0x03 (read), 0x0B (fast read) and 0x02 (write); any other opcode SHALL go to IGNORE.
REQ-018 In ADDR, after 24 bits, SHALL go to DUMMY for 0x0B, RDATA for 0x03, and WDATA for 0x02.
REQ-019 In DUMMY, SHALL count exactly 8 sclk rises and then go to RDATA.
REQ-020 SHALL index the backing store with addr[MEM_AW-1:0]; upper address bits are ignored and the index wraps modulo 2^MEM_AW.
REQ-021 Read path: the synchronous memory read of the current address SHALL be issued on the rise that completes the address (0x03) or the dummy phase (0x0B).
REQ-022 Read path: on the following sclk fall, the responder SHALL assert miso_oe and drive data bit 7.
REQ-023 Read path: each later fall SHALL shift out the next bit; after bit 0 the address SHALL increment and the next byte SHALL be prefetched before the next fall.
REQ-024 Write path: each 8 rises SHALL assemble one byte, written to mem[addr] on the 8th rise, after which addr SHALL increment.
REQ-025 Write path: a partial byte when ce rises SHALL be discarded.
REQ-026 IGNORE SHALL hold miso_oe low and absorb all bits until ce rises.
REQ-027 Synchronized ce rising in any state SHALL force IDLE on the next clk, with miso_oe=0 and bit counter=0.
REQ-028 ce rising SHALL take priority over a coincident sclk edge; no write SHALL occur on that cycle.
REQ-029 ce falling while not in IDLE, which is only possible after a glitch, SHALL restart at CMD.
REQ-030 Outside RDATA and DUMMY->RDATA handoff, miso SHALL be held at 0.
REQ-031 last_cmd SHALL persist across transactions until the next completed opcode.
REQ-032 Correct operation SHALL be guaranteed for clk >= CLK_RATIO_MIN x sclk.

Reset
REQ-033 rst SHALL asynchronously force state=IDLE, psram_miso=0, psram_miso_oe=0, busy=0, last_cmd=0x00, all counters=0, and synchronizer flops to the idle levels (ce=1, sclk=0, mosi=0).
REQ-034 Memory contents SHALL NOT be cleared by rst.
REQ-035 rst asserted mid-transaction SHALL abort it; the first transaction after rst deasserts SHALL begin at a fresh ce falling edge.

Structure
REQ-036 SHALL place opcode constants (OP_READ=0x03, OP_FREAD=0x0B, OP_WRITE=0x02), the state encoding and ADDR_BITS=24 in shared package psram_pkg.
REQ-037 SHALL instantiate one sub-module, spi_edge_sync, providing the synchronizers and rise/fall strobes for sclk and ce.
REQ-038 Backing store SHALL be an inferred single-port synchronous byte RAM inside psram_spi_responder.

Verification
REQ-039 Write 0x02, addr 0x000010, bytes A5 5A C3 3C, then read 0x03 at 0x000010 for 4 bytes -> miso returns A5 5A C3 3C, MSB first, with miso_oe high during data only.
REQ-040 Fast read 0x0B at 0x000011 with 8 dummy clocks -> returns 5A C3 3C.
REQ-041 Write at 0x0003FF of bytes 11 22 (MEM_AW=10) -> read at 0x000000 returns 22; read at 0x0003FF returns 11 (wrap-around).
REQ-042 Opcode 0x9F followed by 32 clocks -> miso_oe stays 0, last_cmd=0x9F, and memory is unchanged.
REQ-043 ce raised after 5 bits of a write data byte, then the location is read -> old value is preserved; busy drops within 3 clk of ce rising.
REQ-044 rst pulsed mid-read at clk:sclk=4 -> miso_oe=0 and last_cmd=0x00 immediately; the next 0x03 transaction returns correct data.
